regfile_sb: RTL

Parametrised multi-read-port register file with same-cycle write-to-read bypass, a hardwired zero register, and a per-register pending-write scoreboard. It replaces the fixed 32×32, two-read-port register file in the pipelined MIPS core. Decode reads operands and issue marks destination registers pending. Writeback writes data and retires the pending mark. Decode uses `rd_busy` to stall on RAW hazards.

---
 rtl/regfile_pkg.sv | 26 ++
 rtl/rf_read_port.sv | 44 ++++
 rtl/regfile_sb.sv | 111 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and counter step helper for the scoreboarded register file
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_CNT_W  = 2;
    localparam int ZERO_IDX   = 0;

    typedef enum logic [1:0] {
        CNT_HOLD = 2'd0,
        CNT_INC  = 2'd1,
        CNT_DEC  = 2'd2
    } cnt_op_e;

    // An issue and a retire landing on the same register cancel out.
    function automatic cnt_op_e cnt_step(input logic inc, input logic dec);
        if (inc && !dec) begin
            return CNT_INC;
        end else if (dec && !inc) begin
            return CNT_DEC;
        end else begin
            return CNT_HOLD;
        end
    endfunction

endpackage

// File: rtl/rf_read_port.sv
// rtl/rf_read_port.sv - one read port: writeback bypass, zero-register masking and busy flag
module rf_read_port
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int CNT_W    = DEF_CNT_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [CNT_W-1:0]  mem_cnt,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_busy
);

    logic             is_zero;
    logic             addr_match;
    logic             retire_hit;
    logic [CNT_W-1:0] cnt_left;

    assign is_zero    = ZERO_REG && (rd_addr == ADDR_W'(ZERO_IDX));
    assign addr_match = wr_en && (wr_addr == rd_addr);
    // A writeback only retires a mark if one is outstanding; a stray one leaves the count at zero.
    assign retire_hit = addr_match && (mem_cnt != '0);
    assign cnt_left   = mem_cnt - CNT_W'(retire_hit);

    // Select bypassed writeback data over the array, with register 0 forced to zero.
    always_comb begin
        rd_data = mem_data;
        rd_busy = (cnt_left != '0);
        if (addr_match) begin
            rd_data = wr_data;
        end
        if (is_zero) begin
            rd_data = '0;
            rd_busy = 1'b0;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port register file with bypass and pending-write scoreboard
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = 2,
    parameter int CNT_W    = DEF_CNT_W,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_rdy,
    output logic                     err
);

    localparam int               DEPTH   = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] mem     [DEPTH];
    logic [CNT_W-1:0]  cnt     [DEPTH];
    logic [CNT_W-1:0]  cnt_nxt [DEPTH];

    logic wr_is_zero;
    logic iss_is_zero;
    logic wr_live;
    logic iss_live;

    assign wr_is_zero  = ZERO_REG && (wr_addr == ADDR_W'(ZERO_IDX));
    assign iss_is_zero = ZERO_REG && (iss_addr == ADDR_W'(ZERO_IDX));
    assign wr_live     = wr_en && !wr_is_zero;
    // iss_rdy looks only at the addressed counter so iss_en never reaches an output.
    assign iss_rdy     = iss_is_zero || (cnt[iss_addr] != CNT_MAX);
    assign iss_live    = iss_en && iss_rdy && !iss_is_zero;

    // Data array: writeback lands at the edge, register 0 stays zero when hardwired.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_live) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Next pending count per register from this cycle's accepted issue and retire.
    always_comb begin
        for (int a = 0; a < DEPTH; a++) begin
            cnt_nxt[a] = cnt[a];
            case (cnt_step(iss_live && (iss_addr == ADDR_W'(a)),
                           wr_live && (wr_addr == ADDR_W'(a)) && (cnt[a] != '0)))
                CNT_INC: cnt_nxt[a] = cnt[a] + CNT_W'(1);
                CNT_DEC: cnt_nxt[a] = cnt[a] - CNT_W'(1);
                default: cnt_nxt[a] = cnt[a];
            endcase
        end
    end

    // Pending counters; reset drops every outstanding mark at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    // Sticky flag for a writeback that found nothing pending to retire.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (wr_live && (cnt[wr_addr] == '0)) begin
            err <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] a;
        assign a = rd_addr[k*ADDR_W +: ADDR_W];

        rf_read_port #(
            .DATA_W   (DATA_W),
            .ADDR_W   (ADDR_W),
            .CNT_W    (CNT_W),
            .ZERO_REG (ZERO_REG)
        ) u_port (
            .rd_addr  (a),
            .mem_data (mem[a]),
            .mem_cnt  (cnt[a]),
            .wr_en    (wr_en),
            .wr_addr  (wr_addr),
            .wr_data  (wr_data),
            .rd_data  (rd_data[k*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy[k])
        );
    end

endmodule
